bnn_argmax_out_serializer: RTL and testbench

Final output stage of the BNN accelerator, directly downstream of the fc1 XNOR-popcount layer. Accepts the 10 class scores for one image serially, one per handshake, and tracks the running maximum. It then drives the chip-level result pins: a 4-bit label sent as two 2-bit beats, MSB pair first, framed by out_en. Upstream is back-pressured while the label is being sent.

---
 rtl/bnn_argmax_out_serializer.sv | 198 +++++++++++++++++++
 tb/tb_bnn_argmax_out_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_argmax_out_serializer.sv
// bnn_argmax_out_serializer
//
// Final output stage of the BNN accelerator. It takes the NUM_CLASS fc1
// popcount scores of one image serially, one per accepted handshake, and keeps
// the running maximum. It then sends the winning class index on the result pins
// as BEATS beats of OUT_W bits each, most significant pair first, framed by out_en.
//
// Handshake: a score is accepted on a rising clk edge where
// score_valid & score_ready are both 1. score_ready is registered, and it is low
// while the label is being sent. score_valid may stay high through that stall;
// nothing is consumed until score_ready returns high.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous frame abort (wins over any handshake)
//   score_in     unsigned score of the current class (class = arrival order)
//   score_valid  score_in is valid
//   score_last   final score of a frame, qualified by the handshake
//   score_ready  registered; 1 = a score can be accepted
//   data_out     serialized label beat, 0 whenever out_en is low
//   out_en       high for exactly BEATS cycles per emitted label
//   label_out    parallel copy of the last emitted label
//   frame_err    sticky frame-length error (cleared by rst_n or clear)
module bnn_argmax_out_serializer #(
  parameter int SCORE_W   = 7,
  parameter int NUM_CLASS = 10,
  parameter int LABEL_W   = 4,
  parameter int OUT_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  input  logic               score_last,
  output logic               score_ready,
  output logic [OUT_W-1:0]   data_out,
  output logic               out_en,
  output logic [LABEL_W-1:0] label_out,
  output logic               frame_err
);

  localparam int BEATS  = LABEL_W / OUT_W;
  localparam int LEFT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_CLASS - 1);

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_n;
  logic [LABEL_W-1:0]  idx_q, idx_n;
  logic [SCORE_W-1:0]  best_q, best_n;
  logic [LABEL_W-1:0]  best_idx_q, best_idx_n;
  // Label bits still waiting to go out, left-aligned.
  logic [LABEL_W-1:0]  sh_q, sh_n;
  // Beats still to be driven after the one currently on the pins.
  logic [LEFT_W-1:0]   left_q, left_n;
  logic [LABEL_W-1:0]  label_q, label_n;
  logic                err_q, err_n;
  logic                ready_q, ready_n;
  logic                out_en_q, out_en_n;
  logic [OUT_W-1:0]    data_q, data_n;

  logic                accept;
  logic                take;
  logic [SCORE_W-1:0]  cand_best;
  logic [LABEL_W-1:0]  cand_idx;

  // Running-max update for the score on the inputs. The first score of a frame
  // always wins. Later scores win only when strictly greater, so ties keep the
  // lowest index.
  always_comb begin
    accept    = score_valid & ready_q;
    take      = (idx_q == '0) || (score_in > best_q);
    cand_best = take ? score_in : best_q;
    cand_idx  = take ? idx_q : best_idx_q;
  end

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    best_n     = best_q;
    best_idx_n = best_idx_q;
    sh_n       = sh_q;
    left_n     = left_q;
    label_n    = label_q;
    err_n      = err_q;
    ready_n    = ready_q;
    out_en_n   = out_en_q;
    data_n     = data_q;

    if (clear) begin
      state_n    = ACC;
      idx_n      = '0;
      best_n     = '0;
      best_idx_n = '0;
      sh_n       = '0;
      left_n     = '0;
      label_n    = '0;
      err_n      = 1'b0;
      ready_n    = 1'b1;
      out_en_n   = 1'b0;
      data_n     = '0;
    end else begin
      case (state_q)
        ACC: begin
          // ready_q is 0 only in the first cycle after reset. Going high here
          // gives the rise on the first edge after reset is released.
          ready_n  = 1'b1;
          out_en_n = 1'b0;
          data_n   = '0;
          if (accept) begin
            best_n     = cand_best;
            best_idx_n = cand_idx;
            if (idx_q == LAST_IDX) begin
              // The frame is complete. The first beat goes out on the next
              // cycle, so it is taken straight from the final compare result.
              idx_n    = '0;
              label_n  = cand_idx;
              err_n    = err_q | ~score_last;
              state_n  = EMIT;
              ready_n  = 1'b0;
              out_en_n = 1'b1;
              data_n   = cand_idx[LABEL_W-1 -: OUT_W];
              sh_n     = cand_idx << OUT_W;
              left_n   = LEFT_W'(BEATS - 1);
            end else if (score_last) begin
              // An early last discards the partial frame and emits nothing.
              idx_n = '0;
              err_n = 1'b1;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end
        end

        EMIT: begin
          if (left_q != '0) begin
            out_en_n = 1'b1;
            data_n   = sh_q[LABEL_W-1 -: OUT_W];
            sh_n     = sh_q << OUT_W;
            left_n   = left_q - 1'b1;
          end else begin
            state_n  = ACC;
            ready_n  = 1'b1;
            out_en_n = 1'b0;
            data_n   = '0;
          end
        end

        default: begin
          state_n  = ACC;
          ready_n  = 1'b1;
          out_en_n = 1'b0;
          data_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      sh_q       <= '0;
      left_q     <= '0;
      label_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      out_en_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      best_q     <= best_n;
      best_idx_q <= best_idx_n;
      sh_q       <= sh_n;
      left_q     <= left_n;
      label_q    <= label_n;
      err_q      <= err_n;
      ready_q    <= ready_n;
      out_en_q   <= out_en_n;
      data_q     <= data_n;
    end
  end

  assign score_ready = ready_q;
  assign out_en      = out_en_q;
  assign data_out    = data_q;
  assign label_out   = label_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_bnn_argmax_out_serializer.sv
// Testbench for bnn_argmax_out_serializer.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge. Expected label beats go into exp_q, and a monitor pops one each time
// out_en is high.
module tb_bnn_argmax_out_serializer;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [6:0] score_in;
  logic       score_valid;
  logic       score_last;
  logic       score_ready;
  logic [1:0] data_out;
  logic       out_en;
  logic [3:0] label_out;
  logic       frame_err;

  bnn_argmax_out_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .score_in    (score_in),
    .score_valid (score_valid),
    .score_last  (score_last),
    .score_ready (score_ready),
    .data_out    (data_out),
    .out_en      (out_en),
    .label_out   (label_out),
    .frame_err   (frame_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (out_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: data_out %0h with no beat expected at %0t",
                 data_out, $time);
      end else begin
        check("beat_data", {30'd0, data_out}, {30'd0, exp_q.pop_front()});
      end
    end else begin
      check("idle_data_zero", {30'd0, data_out}, 32'd0);
    end
  end

  // Driver tasks
  typedef logic [6:0] score_arr_t [10];

  typedef struct {
    score_arr_t s;
    int         last_at;    // -1 = score_last never asserted
    logic [3:0] exp_label;
    logic       exp_err;
  } vec_t;

  // Called at a falling edge. Holds the score until it is accepted, then
  // returns at the falling edge after the accepting rising edge.
  task automatic put_score(input logic [6:0] s, input logic l);
    int guard;
    score_valid = 1'b1;
    score_in    = s;
    score_last  = l;
    guard = 0;
    while (score_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Sends a full 10-score frame and checks the emit timing. score_valid is
  // left high so frames can run back to back.
  task automatic run_frame(input score_arr_t s, input int last_at,
                           input logic [3:0] exp_label, input logic exp_err);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        exp_q.push_back(exp_label[3:2]);
        exp_q.push_back(exp_label[1:0]);
      end
      put_score(s[i], (i == last_at));
    end
    check("beat1_out_en", {31'd0, out_en}, 32'd1);
    check("beat1_ready", {31'd0, score_ready}, 32'd0);
    check("label_out", {28'd0, label_out}, {28'd0, exp_label});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    @(negedge clk);
    check("beat2_out_en", {31'd0, out_en}, 32'd1);
    check("beat2_ready", {31'd0, score_ready}, 32'd0);
    @(negedge clk);
    check("post_out_en", {31'd0, out_en}, 32'd0);
    check("post_ready", {31'd0, score_ready}, 32'd1);
  endtask

  task automatic do_clear();
    exp_q.delete();
    score_valid = 1'b0;
    score_last  = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_out_en", {31'd0, out_en}, 32'd0);
    check("clr_err", {31'd0, frame_err}, 32'd0);
    check("clr_label", {28'd0, label_out}, 32'd0);
    check("clr_ready", {31'd0, score_ready}, 32'd1);
  endtask

  // Test sequence
  vec_t       vecs [4];
  score_arr_t fs;

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    score_in    = '0;
    score_valid = 1'b0;
    score_last  = 1'b0;

    vecs[0] = '{s: '{7'd3, 7'd10, 7'd50, 7'd7, 7'd96, 7'd0, 7'd1, 7'd2, 7'd95, 7'd4},
                last_at: 9, exp_label: 4'd4, exp_err: 1'b0};
    vecs[1] = '{s: '{7'd20, 7'd20, 7'd40, 7'd20, 7'd20, 7'd20, 7'd20, 7'd20, 7'd20, 7'd40},
                last_at: 9, exp_label: 4'd2, exp_err: 1'b0};
    vecs[2] = '{s: '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd96},
                last_at: 9, exp_label: 4'd9, exp_err: 1'b0};
    vecs[3] = '{s: '{7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 7'd90, 7'd12, 7'd13},
                last_at: -1, exp_label: 4'd7, exp_err: 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, score_ready}, 32'd0);
    check("rst_out_en", {31'd0, out_en}, 32'd0);
    check("rst_label", {28'd0, label_out}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    check("ready_before_edge", {31'd0, score_ready}, 32'd0);
    @(negedge clk);
    check("ready_first_edge", {31'd0, score_ready}, 32'd1);

    // Table frames, score_valid held high throughout (back-pressure)
    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].s, vecs[i].last_at, vecs[i].exp_label, vecs[i].exp_err);
    score_valid = 1'b0;
    score_last  = 1'b0;
    @(negedge clk);
    check("label_hold", {28'd0, label_out}, 32'd7);
    check("err_sticky", {31'd0, frame_err}, 32'd1);

    // Early last on the 5th score: error, no emit
    do_clear();
    for (int i = 0; i < 5; i++) put_score(7'(10 + i), (i == 4));
    score_valid = 1'b0;
    score_last  = 1'b0;
    check("early_err", {31'd0, frame_err}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("early_no_emit", {31'd0, out_en}, 32'd0);
    end
    fs = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd60, 7'd6, 7'd7, 7'd8, 7'd9};
    run_frame(fs, 9, 4'd5, 1'b1);
    score_valid = 1'b0;
    @(negedge clk);
    check("err_still_set", {31'd0, frame_err}, 32'd1);
    do_clear();

    // Clear after 6 scores, with a competing handshake in the clear cycle
    for (int i = 0; i < 6; i++) put_score(7'd50, 1'b0);
    score_in    = 7'd96;
    score_valid = 1'b1;
    clear       = 1'b1;
    @(negedge clk);
    clear       = 1'b0;
    score_valid = 1'b0;
    check("mid_clr_ready", {31'd0, score_ready}, 32'd1);
    check("mid_clr_out_en", {31'd0, out_en}, 32'd0);
    fs = '{7'd1, 7'd2, 7'd3, 7'd70, 7'd5, 7'd6, 7'd70, 7'd7, 7'd8, 7'd9};
    run_frame(fs, 9, 4'd3, 1'b0);
    score_valid = 1'b0;

    // Clear during beat 1
    for (int i = 0; i < 10; i++) begin
      if (i == 9) exp_q.push_back(2'b10);   // label 9, only the first beat goes out
      put_score((i == 9) ? 7'd80 : 7'd1, (i == 9));
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
    check("abort_beat1_out_en", {31'd0, out_en}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_out_en_drop", {31'd0, out_en}, 32'd0);
    check("abort_ready", {31'd0, score_ready}, 32'd1);
    check("abort_label", {28'd0, label_out}, 32'd0);
    fs = '{7'd9, 7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    run_frame(fs, 9, 4'd0, 1'b0);
    score_valid = 1'b0;

    // Async reset during EMIT
    fs = '{7'd1, 7'd90, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) exp_q.push_back(2'b00);   // label 1, first beat only
      put_score(fs[i], (i == 9));
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_en", {31'd0, out_en}, 32'd0);
    check("arst_data", {30'd0, data_out}, 32'd0);
    check("arst_ready", {31'd0, score_ready}, 32'd0);
    check("arst_label", {28'd0, label_out}, 32'd0);
    check("arst_err", {31'd0, frame_err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready_rise", {31'd0, score_ready}, 32'd1);
    run_frame(vecs[0].s, 9, 4'd4, 1'b0);
    score_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
